pc_sequencer: RTL

//   Program-counter stage downstream of ALU_Control/Control: holds the architectural PC and

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_register.sv | 22 ++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: reset PC, next-PC select codes, FSM states.
// Pure definitions; no latency or flow-control behaviour of its own.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  typedef enum logic [1:0] {
    SEL_PC4 = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_JR  = 2'd3
  } nxt_sel_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_register.sv
// Enabled register with async active-low reset to a fixed value.
// One-cycle latency d->q; holds whenever en is low.
module pc_register #(
  parameter int          WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Holds the PC, selects next PC (JR > J/JAL > taken branch > PC+4), traps misaligned targets.
// next_pc is combinational; PC updates on the following edge; enable_i low stalls everything.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             branch_eq_i,
  input  logic             branch_ne_i,
  input  logic             zero_i,
  input  logic             jump_i,
  input  logic             jump_register_i,
  input  logic             return_address_i,
  input  logic [31:0]      imm_ext_i,
  input  logic [25:0]      jump_addr_i,
  input  logic [31:0]      rs_data_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic [31:0]      ra_value_o,
  output logic             ra_write_o,
  output logic             align_fault_o,
  output logic [CNT_W-1:0] retired_count_o,
  output logic [CNT_W-1:0] taken_count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state_q, state_d;
  nxt_sel_t    sel;
  logic [31:0] pc_plus4, br_tgt, j_tgt, next_pc;
  logic        taken, aligned, advance;
  logic        unused_imm_hi;

  // Word offset drops the top two immediate bits after the shift.
  assign unused_imm_hi = ^imm_ext_i[31:30];

  assign pc_plus4 = pc_o + 32'd4;
  assign br_tgt   = pc_plus4 + {imm_ext_i[29:0], 2'b00};
  assign j_tgt    = {pc_plus4[31:28], jump_addr_i, 2'b00};

  always_comb begin
    sel = SEL_PC4;
    if (jump_register_i) begin
      sel = SEL_JR;
    end else if (jump_i || return_address_i) begin
      sel = SEL_JMP;
    end else if ((branch_eq_i && zero_i) || (branch_ne_i && !zero_i)) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_BR:  next_pc = br_tgt;
      SEL_JMP: next_pc = j_tgt;
      SEL_JR:  next_pc = rs_data_i;
      default: next_pc = pc_plus4;
    endcase
  end

  assign taken   = (sel != SEL_PC4);
  assign aligned = (next_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (enable_i) begin
          if (aligned) begin
            advance = 1'b1;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  pc_register #(
    .WIDTH       (32),
    .RESET_VALUE (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (advance),
    .d     (next_pc),
    .q     (pc_o)
  );

  // Counters saturate rather than wrap so long runs never read back as small.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_count_o <= '0;
      taken_count_o   <= '0;
    end else if (advance) begin
      if (!(&retired_count_o)) retired_count_o <= retired_count_o + CNT_ONE;
      if (taken && !(&taken_count_o)) taken_count_o <= taken_count_o + CNT_ONE;
    end
  end

  assign pc_plus4_o    = pc_plus4;
  assign ra_value_o    = pc_plus4;
  assign ra_write_o    = return_address_i && advance && reset;
  assign align_fault_o = (state_q == ST_FAULT);

endmodule
